// File: rtl/prog_loader.sv
// Program loader: assembles a little-endian byte stream (8-byte start PC header, then
// 32-bit instructions) into instruction-memory writes, then releases the core from reset.
module prog_loader #(
   parameter int IMEM_AW     = 8,
   parameter int RELEASE_CYC = 2
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               s_valid,
   input  logic [7:0]         s_data,
   input  logic               s_last,
   output logic               s_ready,
   output logic               imem_we,
   output logic [63:0]        imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               proc_resetl,
   output logic [63:0]        startpc,
   output logic               load_done,
   output logic               err,
   output logic [IMEM_AW:0]   word_count
);

   typedef enum logic [2:0] {HDR, BODY, WRITE, RELEASE, RUN, ERR} state_t;

   localparam logic [IMEM_AW:0] DEPTH = {1'b1, {IMEM_AW{1'b0}}};
   localparam int RC_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RELEASE_CYC - 1);

   state_t            state_q, state_d;
   logic [2:0]        hdr_cnt_q, hdr_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       buf_q, buf_d;
   logic              last_q, last_d;
   logic [RC_W-1:0]   rel_cnt_q, rel_cnt_d;
   logic [63:0]       startpc_q, startpc_d;
   logic [63:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [IMEM_AW:0]  wcnt_q, wcnt_d;
   logic              err_q, err_d;
   logic              resetl_q, resetl_d;
   logic              done_q, done_d;
   logic              accept;
   logic [31:0]       word;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q    <= HDR;
         hdr_cnt_q  <= '0;
         byte_idx_q <= '0;
         buf_q      <= '0;
         last_q     <= 1'b0;
         rel_cnt_q  <= '0;
         startpc_q  <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wcnt_q     <= '0;
         err_q      <= 1'b0;
         resetl_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_cnt_q  <= hdr_cnt_d;
         byte_idx_q <= byte_idx_d;
         buf_q      <= buf_d;
         last_q     <= last_d;
         rel_cnt_q  <= rel_cnt_d;
         startpc_q  <= startpc_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wcnt_q     <= wcnt_d;
         err_q      <= err_d;
         resetl_q   <= resetl_d;
         done_q     <= done_d;
      end
   end

   assign s_ready = (state_q == HDR) || (state_q == BODY);
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      byte_idx_d = byte_idx_q;
      buf_d      = buf_q;
      last_d     = last_q;
      rel_cnt_d  = rel_cnt_q;
      startpc_d  = startpc_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wcnt_d     = wcnt_q;
      err_d      = err_q;
      resetl_d   = resetl_q;
      done_d     = done_q;
      word       = buf_q | ({24'b0, s_data} << {byte_idx_q, 3'b000});
      case (state_q)
         HDR: begin
            if (accept) begin
               // Shift in from the top so byte 0 lands in bits 7:0 after eight bytes.
               startpc_d = {s_data, startpc_q[63:8]};
               hdr_cnt_d = hdr_cnt_q + 3'd1;
               if (s_last) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end else if (hdr_cnt_q == 3'd7) begin
                  if (startpc_d[1:0] != 2'b00) begin
                     err_d   = 1'b1;
                     state_d = ERR;
                  end else begin
                     state_d = BODY;
                  end
               end
            end
         end
         BODY: begin
            if (accept) begin
               if (err_q) begin
                  // Overflowed: swallow the rest of the program until its last byte.
                  if (s_last) state_d = ERR;
               end else if ((byte_idx_q == 2'd3) || s_last) begin
                  byte_idx_d = '0;
                  buf_d      = '0;
                  if (wcnt_q == DEPTH) begin
                     err_d = 1'b1;
                     if (s_last) state_d = ERR;
                  end else begin
                     wdata_d = word;
                     addr_d  = 64'({wcnt_q, 2'b00});
                     last_d  = s_last;
                     state_d = WRITE;
                  end
               end else begin
                  buf_d      = word;
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
         WRITE: begin
            wcnt_d    = wcnt_q + 1'b1;
            rel_cnt_d = '0;
            state_d   = last_q ? RELEASE : BODY;
         end
         RELEASE: begin
            if (rel_cnt_q == RC_LAST) begin
               resetl_d = 1'b1;
               done_d   = 1'b1;
               state_d  = RUN;
            end else begin
               rel_cnt_d = rel_cnt_q + 1'b1;
            end
         end
         RUN, ERR: ;
         default: state_d = HDR;
      endcase
   end

   assign imem_we     = (state_q == WRITE);
   assign imem_addr   = addr_q;
   assign imem_wdata  = wdata_q;
   assign proc_resetl = resetl_q;
   assign startpc     = startpc_q;
   assign load_done   = done_q;
   assign err         = err_q;
   assign word_count  = wcnt_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side counterpart to the processor's instruction fetch.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Writes those instructions into instruction memory from address 0 upward, then releases the processor from reset with a loaded start PC.
- Sits between the host/bench byte source and the singlecycle core's instruction memory write port and its resetl/startpc inputs.

Parameters:
- IMEM_AW, 8, instruction memory depth in words = 2^IMEM_AW.
- RELEASE_CYC, 2, cycles proc_resetl is held low after the final write.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- s_valid  in  1  byte available.
- s_data  in  8  stream byte.
- s_last  in  1  marks final byte of the program.
- s_ready  out  1  loader accepts byte this cycle.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  64  byte address of write = word_index*4.
- imem_wdata  out  32  assembled instruction.
- proc_resetl  out  1  drives core resetl; low holds core in reset.
- startpc  out  64  start PC presented to core.
- load_done  out  1  core released; program loaded.
- err  out  1  sticky error flag.
- word_count  out  IMEM_AW+1  words written.

Behaviour:
- Byte transfer occurs on a rising CLK edge where s_valid and s_ready are both 1.
- s_ready is decoded from state: 1 in HDR and BODY, 0 in all other states.
- Stream format:
  - Bytes 0-7: start PC, little-endian (byte 0 = bits 7:0).
  - Bytes 8 onward: instructions, 4 bytes per word, little-endian.
- Async reset values:
  - state = HDR.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - proc_resetl = 0, startpc = 0, load_done = 0, err = 0, word_count = 0.
  - Internal byte counters = 0.
  - Reset asserted mid-operation aborts immediately to these values; a partial word is discarded.
- HDR:
  - Shift accepted bytes into the startpc register.
  - After the 8th byte with startpc[1:0] != 0: set err and go to ERR.
  - After the 8th byte, aligned: go to BODY.
  - s_last on any header byte: set err and go to ERR.
- BODY:
  - Accepted byte fills lane byte_idx of the word buffer.
  - When byte_idx==3, or s_last is set: go to WRITE.
  - A partial final word has its unfilled upper lanes zero-padded. This is not an error.
  - If word_count == 2^IMEM_AW when a word completes: set err, drop the word, and stay in BODY discarding bytes. On s_last, go to ERR.
- WRITE (exactly 1 cycle):
  - imem_we = 1, imem_wdata = buffer, imem_addr = word_count*4.
  - word_count increments at the end of the cycle; the buffer clears.
  - Next state is RELEASE if the word was last, otherwise BODY.
  - Write latency: the strobe is asserted the cycle after the 4th byte is accepted. At most 1 word per 5 cycles at full rate.
- RELEASE:
  - proc_resetl stays 0 for RELEASE_CYC cycles, then go to RUN.
- RUN:
  - proc_resetl = 1, load_done = 1.
  - Terminal until reset; s_ready = 0.
- ERR:
  - Terminal until reset.
  - proc_resetl = 0, err = 1, load_done = 0, s_ready = 0.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- Only imem_we is a pulse; all other outputs are registered levels.
- A byte presented while s_ready = 0 is not consumed and must remain held by the source.

Test Plan:
- Reset behaviour: assert reset asynchronously mid-cycle -> all outputs reach their reset values without waiting for CLK; after release, s_ready = 1 and state is HDR.
- Basic load: header 0x0, then words 0xF84003E9, 0x8B0A0129, 0xB400000F, last on the final byte.
  - Three imem_we pulses at addr 0x0, 0x4, 0x8 with those data.
  - proc_resetl low for exactly 2 cycles after the third pulse, then 1.
  - load_done = 1, word_count = 3, startpc = 0.
- Backpressure: s_valid toggles randomly with s_ready low during WRITE -> no byte lost or duplicated; the written words equal the basic-load words.
- Partial last word: header 0x30, then body bytes AA BB CC DD EE FF with last on FF.
  - Writes 0xDDCCBBAA at addr 0x0 and 0x0000FFEE at addr 0x4.
  - startpc = 0x30, err = 0.
- Errors:
  - s_last on header byte 5 -> ERR: err = 1, proc_resetl stays 0, no imem_we.
  - Header 0x2 -> err = 1 after byte 8.
- Overflow and abort:
  - IMEM_AW = 2 with 5 words -> 4 writes (addr 0x0-0xC), err = 1, final state ERR, word_count = 4.
  - Reset pulse after 2 body bytes -> word_count = 0 and a fresh load succeeds.
